fp32_to_int_seq: RTL and testbench
==================================

// Module: fp32_to_int_seq
// PURPOSE
//  Multi-cycle IEEE-754 single-precision to signed-integer converter; decodes the fp32 word that floating_unit produces.
//  Sits after the FP adder result path, feeding integer datapaths; valid/ready on both sides, one conversion in flight.
//  Rounding fixed: truncate toward zero. Iterative 1-bit shifter trades latency for area.
// PARAMETERS
//  OUT_W  32  integer result width, legal 16..32; overflow threshold scales with it.
// PORTS
//  clk          in   1      clock, all state on rising edge
//  rst          in   1      reset, asynchronous, active-high
//  in_data      in   32     fp32 operand {sign, exp[7:0], mant[22:0]}
//  in_valid     in   1      operand present
//  in_ready     out  1      block idle, operand accepted on in_valid & in_ready
//  out_data     out  OUT_W  signed integer result
//  out_valid    out  1      result + flags valid
//  out_ready    in   1      consumer accepts on out_valid & out_ready
//  out_invalid  out  1      NaN, +/-inf, or out of range (result saturated)
//  out_inexact  out  1      nonzero fraction bits discarded
// BEHAVIOUR
//  Reset: state IDLE; out_data=0, out_valid=0, out_invalid=0, out_inexact=0; in_ready=1. rst mid-operation aborts, no result emitted.
//  in_ready = (state==IDLE), combinational from state; in_valid while busy is ignored, not queued.
//  FSM: IDLE -accept-> CLASSIFY -> SHIFT (n cycles, skipped if n=0) -> FINISH -> DONE -(out_ready)-> IDLE.
//  CLASSIFY: latch sign, classify exp/mant; acc[31:0] = {8'b0, 1'b1, mant}; load n, dir, special flag.
//   zero (E=0,M=0): special, result 0, no flags. subnormal (E=0,M!=0) or 0<E<127: special, result 0, inexact=1.
//   NaN (E=FF,M!=0): result 2^(OUT_W-1)-1, invalid=1. +inf: 2^(OUT_W-1)-1, invalid. -inf: -2^(OUT_W-1), invalid.
//   E >= 127+OUT_W-1: overflow, saturate by sign, invalid=1; exception: S=1, M=0, E==127+OUT_W-1 -> -2^(OUT_W-1), no flags.
//   in range, E<=150: right shift, n=150-E (0..23). 150<E<127+OUT_W-1: left shift, n=E-150 (1..OUT_W-25).
//  SHIFT: one bit per cycle, 5-bit down-counter n; right shift ORs bit shifted out into sticky; left shift fills 0.
//  FINISH: inexact=sticky; out_data = sign ? -acc[OUT_W-1:0] : acc[OUT_W-1:0] (two's complement); -0 -> 0.
//  DONE: out_valid=1; out_data/flags stable while out_valid & !out_ready; leave on out_ready same edge.
//  Latency: out_valid high n+3 cycles after accept edge (specials n=0 -> 3). Max 26 (E=127). Throughput 1 per latency+1 cycles min.
//  No back-to-back overlap: new accept only in IDLE, i.e. cycle after DONE handshake.
// STRUCTURE
//  Package fp32_pkg: EXP_BIAS=127, MANT_W=23, EXP_W=8, EXP_INF=8'hFF, MANT_ALIGN=150; class enum
//   {ZERO=3'b000, SUBN=3'b001, NORM=3'b011, INF=3'b100, NAN=3'b110} shared with floating_unit classification; FSM state enum.
//  Sub-module fp32_classify (combinational: in fp32 -> class, sign, exp, mant); top holds FSM, counter, acc, sticky, sat logic.
// TESTING
//  0x3F800000 (1.0) -> out_data=1, flags 0, out_valid exactly 26 cycles after accept.
//  0xC2F6E979 (-123.456) -> 0xFFFFFF85, inexact=1, invalid=0, latency 20 (n=17).
//  0x4F000000 (2^31) -> 0x7FFFFFFF invalid=1; 0xCF000000 -> 0x80000000 no flags; 0x4EFFFFFF -> 0x7FFFFF80 no flags (n=7).
//  0x7FC00000 -> 0x7FFFFFFF invalid; 0xFF800000 -> 0x80000000 invalid; 0x00000001 -> 0 inexact; 0x80000000 -> 0 no flags.
//  Backpressure: out_ready low 5 cycles in DONE -> out_data/flags held, in_ready=0, second in_valid not taken until after handshake.
//  Assert rst during SHIFT of 0x3F800000 -> outputs to reset values immediately; next 0x40400000 (3.0) -> 3 with no residue.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared fp32 field constants, operand classes and converter FSM states.
// The class encoding matches the one used by floating_unit.
package fp32_pkg;

    localparam int EXP_BIAS   = 127;
    localparam int MANT_W     = 23;
    localparam int EXP_W      = 8;
    localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;
    localparam int MANT_ALIGN = 150;

    typedef enum logic [2:0] {
        CLS_ZERO = 3'b000,
        CLS_SUBN = 3'b001,
        CLS_NORM = 3'b011,
        CLS_INF  = 3'b100,
        CLS_NAN  = 3'b110
    } fp_class_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLASSIFY,
        ST_SHIFT,
        ST_FINISH,
        ST_DONE
    } state_e;

endpackage

// File: rtl/fp32_classify.sv
// Combinational split of an fp32 word into sign/exponent/mantissa plus its class.
module fp32_classify
    import fp32_pkg::*;
(
    input  logic [31:0]       i_data,
    output fp_class_e         o_class,
    output logic              o_sign,
    output logic [EXP_W-1:0]  o_exp,
    output logic [MANT_W-1:0] o_mant
);

    assign o_sign = i_data[31];
    assign o_exp  = i_data[30:23];
    assign o_mant = i_data[22:0];

    always_comb begin
        o_class = CLS_NORM;
        if (o_exp == '0) begin
            o_class = (o_mant == '0) ? CLS_ZERO : CLS_SUBN;
        end else if (o_exp == EXP_INF) begin
            o_class = (o_mant == '0) ? CLS_INF : CLS_NAN;
        end
    end

endmodule

// File: rtl/fp32_to_int_seq.sv
// Multi-cycle fp32 -> signed integer converter, truncating toward zero.
// One operand in flight; the mantissa is aligned by a 1-bit-per-cycle shifter.
module fp32_to_int_seq
    import fp32_pkg::*;
#(
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_invalid,
    output logic             out_inexact
);

    localparam logic [OUT_W-1:0] SAT_POS   = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_NEG   = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [EXP_W-1:0] BIAS_EXP  = EXP_W'(EXP_BIAS);
    localparam logic [EXP_W-1:0] ALIGN_EXP = EXP_W'(MANT_ALIGN);
    localparam logic [EXP_W-1:0] OVF_EXP   = EXP_W'(EXP_BIAS + OUT_W - 1);

    state_e r_state;
    state_e w_state_next;

    logic [31:0]      r_in_data;
    logic [31:0]      r_acc;
    logic [4:0]       r_cnt;
    logic             r_sign;
    logic             r_dir_left;
    logic             r_sticky;
    logic             r_special;
    logic [OUT_W-1:0] r_spec_data;
    logic             r_spec_invalid;
    logic             r_spec_inexact;
    logic [OUT_W-1:0] r_out_data;
    logic             r_out_invalid;
    logic             r_out_inexact;

    fp_class_e         w_class;
    logic              w_sign;
    logic [EXP_W-1:0]  w_exp;
    logic [MANT_W-1:0] w_mant;
    logic              w_special;
    logic [OUT_W-1:0]  w_spec_data;
    logic              w_spec_invalid;
    logic              w_spec_inexact;
    logic              w_dir_left;
    logic [4:0]        w_n;
    logic [OUT_W-1:0]  w_mag;

    fp32_classify u_classify (
        .i_data  (r_in_data),
        .o_class (w_class),
        .o_sign  (w_sign),
        .o_exp   (w_exp),
        .o_mant  (w_mant)
    );

    // Decide shift direction/count or a directly known (special) result.
    always_comb begin
        w_special      = 1'b0;
        w_spec_data    = '0;
        w_spec_invalid = 1'b0;
        w_spec_inexact = 1'b0;
        w_dir_left     = 1'b0;
        w_n            = '0;
        case (w_class)
            CLS_ZERO: begin
                w_special = 1'b1;
            end
            CLS_SUBN: begin
                w_special      = 1'b1;
                w_spec_inexact = 1'b1;
            end
            CLS_INF: begin
                w_special      = 1'b1;
                w_spec_invalid = 1'b1;
                w_spec_data    = w_sign ? SAT_NEG : SAT_POS;
            end
            CLS_NAN: begin
                w_special      = 1'b1;
                w_spec_invalid = 1'b1;
                w_spec_data    = SAT_POS;
            end
            default: begin
                if (w_exp < BIAS_EXP) begin
                    w_special      = 1'b1;
                    w_spec_inexact = 1'b1;
                end else if (w_exp == OVF_EXP && w_sign && w_mant == '0) begin
                    // -2^(OUT_W-1) is exactly representable
                    w_special   = 1'b1;
                    w_spec_data = SAT_NEG;
                end else if (w_exp >= OVF_EXP) begin
                    w_special      = 1'b1;
                    w_spec_invalid = 1'b1;
                    w_spec_data    = w_sign ? SAT_NEG : SAT_POS;
                end else if (w_exp <= ALIGN_EXP) begin
                    w_n = 5'(ALIGN_EXP - w_exp);
                end else begin
                    w_dir_left = 1'b1;
                    w_n        = 5'(w_exp - ALIGN_EXP);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:     if (in_valid) w_state_next = ST_CLASSIFY;
            ST_CLASSIFY: w_state_next = (w_n == '0) ? ST_FINISH : ST_SHIFT;
            ST_SHIFT:    if (r_cnt == 5'd1) w_state_next = ST_FINISH;
            ST_FINISH:   w_state_next = ST_DONE;
            ST_DONE:     if (out_ready) w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    assign w_mag = r_acc[OUT_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_data      <= '0;
            r_acc          <= '0;
            r_cnt          <= '0;
            r_sign         <= 1'b0;
            r_dir_left     <= 1'b0;
            r_sticky       <= 1'b0;
            r_special      <= 1'b0;
            r_spec_data    <= '0;
            r_spec_invalid <= 1'b0;
            r_spec_inexact <= 1'b0;
            r_out_data     <= '0;
            r_out_invalid  <= 1'b0;
            r_out_inexact  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) r_in_data <= in_data;
                end
                ST_CLASSIFY: begin
                    r_sign         <= w_sign;
                    r_acc          <= {8'b0, 1'b1, w_mant};
                    r_cnt          <= w_n;
                    r_dir_left     <= w_dir_left;
                    r_sticky       <= 1'b0;
                    r_special      <= w_special;
                    r_spec_data    <= w_spec_data;
                    r_spec_invalid <= w_spec_invalid;
                    r_spec_inexact <= w_spec_inexact;
                end
                ST_SHIFT: begin
                    r_cnt <= r_cnt - 5'd1;
                    if (r_dir_left) begin
                        r_acc <= {r_acc[30:0], 1'b0};
                    end else begin
                        r_acc    <= {1'b0, r_acc[31:1]};
                        r_sticky <= r_sticky | r_acc[0];
                    end
                end
                ST_FINISH: begin
                    if (r_special) begin
                        r_out_data    <= r_spec_data;
                        r_out_invalid <= r_spec_invalid;
                        r_out_inexact <= r_spec_inexact;
                    end else begin
                        r_out_data    <= r_sign ? -w_mag : w_mag;
                        r_out_invalid <= 1'b0;
                        r_out_inexact <= r_sticky;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (r_state == ST_IDLE);
    assign out_valid   = (r_state == ST_DONE);
    assign out_data    = r_out_data;
    assign out_invalid = r_out_invalid;
    assign out_inexact = r_out_inexact;

endmodule

// File: tb/tb_fp32_to_int_seq.sv
// Directed-vector bench for fp32_to_int_seq: results, flags, latency, backpressure, reset abort.
module tb_fp32_to_int_seq;

    localparam int OUT_W = 32;

    logic             clk;
    logic             rst;
    logic [31:0]      in_data;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_invalid;
    logic             out_inexact;

    int n_checks;
    int n_fails;

    typedef struct {
        logic [31:0] din;
        logic [31:0] dout;
        logic        inv;
        logic        inx;
        int          lat;
    } vec_t;

    vec_t vq[$];

    fp32_to_int_seq #(.OUT_W(OUT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_invalid (out_invalid),
        .out_inexact (out_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    // Present one operand and return right after the accepting edge.
    task automatic send(input logic [31:0] data);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        in_data  = data;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Cycle 0 is the accepting cycle; return the cycle index where out_valid first appears.
    task automatic wait_out(output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) chk("result_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic expect_out(input string tag, input logic [31:0] dout,
                              input logic inv, input logic inx, input int lat_exp);
        int lat;
        wait_out(lat);
        $display("%s: out_data=0x%08h invalid=%0b inexact=%0b latency=%0d", tag, out_data,
                 out_invalid, out_inexact, lat);
        chk({tag, "_lat"}, 32'(lat), 32'(lat_exp));
        chk({tag, "_data"}, out_data, dout);
        chk({tag, "_invalid"}, 32'(out_invalid), 32'(inv));
        chk({tag, "_inexact"}, 32'(out_inexact), 32'(inx));
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        vq.push_back('{32'h3F800000, 32'h00000001, 1'b0, 1'b0, 26});
        vq.push_back('{32'hC2F6E979, 32'hFFFFFF85, 1'b0, 1'b1, 20});
        vq.push_back('{32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b0, 3});
        vq.push_back('{32'hCF000000, 32'h80000000, 1'b0, 1'b0, 3});
        vq.push_back('{32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0, 10});
        vq.push_back('{32'h7FC00000, 32'h7FFFFFFF, 1'b1, 1'b0, 3});
        vq.push_back('{32'hFF800000, 32'h80000000, 1'b1, 1'b0, 3});
        vq.push_back('{32'h00000001, 32'h00000000, 1'b0, 1'b1, 3});
        vq.push_back('{32'h80000000, 32'h00000000, 1'b0, 1'b0, 3});
        vq.push_back('{32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0, 3});
        vq.push_back('{32'h3F000000, 32'h00000000, 1'b0, 1'b1, 3});
        vq.push_back('{32'h4B000001, 32'h00800001, 1'b0, 1'b0, 3});
        vq.push_back('{32'hCF800000, 32'h80000000, 1'b1, 1'b0, 3});
        vq.push_back('{32'hBFC00000, 32'hFFFFFFFF, 1'b0, 1'b1, 26});
        vq.push_back('{32'h3F800001, 32'h00000001, 1'b0, 1'b1, 26});

        repeat (3) @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", out_data, 32'd0);
        chk("reset_flags", {30'd0, out_invalid, out_inexact}, 32'd0);
        rst = 1'b0;

        foreach (vq[i]) begin
            send(vq[i].din);
            expect_out($sformatf("v%0d_%08h", i, vq[i].din), vq[i].dout, vq[i].inv,
                       vq[i].inx, vq[i].lat);
            pop();
        end

        // Backpressure: hold DONE with a competing operand offered.
        send(32'h40400000);
        expect_out("bp_first", 32'd3, 1'b0, 1'b0, 25);
        in_data  = 32'h3F800000;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            $display("bp_hold cycle %0d: out_valid=%0b out_data=0x%08h in_ready=%0b", c,
                     out_valid, out_data, in_ready);
            chk($sformatf("bp_hold%0d_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp_hold%0d_data", c), out_data, 32'd3);
            chk($sformatf("bp_hold%0d_in_ready", c), 32'(in_ready), 32'd0);
            chk($sformatf("bp_hold%0d_flags", c), {30'd0, out_invalid, out_inexact}, 32'd0);
        end
        pop();
        @(negedge clk);
        chk("bp_idle_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        expect_out("bp_second", 32'd1, 1'b0, 1'b0, 26);
        pop();

        // Reset in the middle of the shift phase aborts the conversion.
        send(32'h3F800000);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        $display("rst_abort: out_valid=%0b in_ready=%0b out_data=0x%08h", out_valid, in_ready,
                 out_data);
        chk("rst_abort_out_valid", 32'(out_valid), 32'd0);
        chk("rst_abort_in_ready", 32'(in_ready), 32'd1);
        chk("rst_abort_out_data", out_data, 32'd0);
        chk("rst_abort_flags", {30'd0, out_invalid, out_inexact}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send(32'h40400000);
        expect_out("post_rst_3p0", 32'd3, 1'b0, 1'b0, 25);
        pop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
